// File: rtl/window_counter_pkg.sv
// Shared definitions for the window_counter scan generator.
//   state_t   : FSM state encoding (IDLE, RUN, FIN)
//   DEF_ADD_W : default width of the linear address output
//   DEF_CNT_W : default width of the row/column counters and limits
package window_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int DEF_ADD_W = 10;
    localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/window_counter_mod_counter.sv
// mod_counter: CNT_W-bit modulo counter with programmable step and limit.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   ce_i           : advance by step_i (wraps to 0 when count+step >= limit)
//   sclr_i         : synchronous clear to 0 (highest priority)
//   load_zero_i    : synchronous load of 0 (start of a new scan)
//   step_i         : increment applied on each enabled advance
//   limit_i        : modulus; the count wraps once count+step reaches it
//   count_o        : current count (registered)
//   count_nxt_o    : value the count takes at the next clock edge
//   carry_o        : terminal flag, count+step >= limit
module mod_counter
    import window_counter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             sclr_i,
    input  logic             load_zero_i,
    input  logic [CNT_W-1:0] step_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_nxt_o,
    output logic             carry_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   sum;

    // One extra bit so a count near the top of the range cannot wrap
    // around and look smaller than the limit.
    assign sum     = {1'b0, count_q} + {1'b0, step_i};
    assign carry_o = (sum >= {1'b0, limit_i});

    always_comb begin
        count_d = count_q;
        if (sclr_i || load_zero_i) begin
            count_d = '0;
        end else if (ce_i) begin
            count_d = carry_o ? '0 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign count_nxt_o = count_d;

endmodule

// File: rtl/window_counter.sv
// window_counter: raster scan generator over a COLS x ROWS window.
// Emits column/row indices and the linear address ROW*PITCH + COL
// (modulo 2^Add_W), stepping columns by STRIDE.
//   CLK, RST          : clock, asynchronous active-high reset
//   START             : begin a scan (sampled in IDLE only)
//   CE                : advance enable, the scan holds while low
//   SCLR              : synchronous abort, overrides START and CE
//   COLS, ROWS, PITCH : window geometry, latched when the scan starts
//   COL_Q, ROW_Q      : current column / row index
//   ADDR              : current linear address
//   VALID, LAST       : live scan point / final point of the scan
//   BUSY, DONE        : scan in progress / one-cycle completion pulse
//   dbg_state_o       : current FSM state
//
// Flow control: the point on COL_Q/ROW_Q/ADDR is offered while VALID=1
// and is consumed on every rising edge where CE=1; with CE=0 the point and
// LAST hold. Consuming the point flagged by LAST ends the scan, and DONE
// pulses in the following cycle.
module window_counter
    import window_counter_pkg::*;
#(
    parameter int Add_W  = DEF_ADD_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STRIDE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CE,
    input  logic             SCLR,
    input  logic [CNT_W-1:0] COLS,
    input  logic [CNT_W-1:0] ROWS,
    input  logic [Add_W-1:0] PITCH,
    output logic [CNT_W-1:0] COL_Q,
    output logic [CNT_W-1:0] ROW_Q,
    output logic [Add_W-1:0] ADDR,
    output logic             VALID,
    output logic             LAST,
    output logic             BUSY,
    output logic             DONE,
    output state_t           dbg_state_o
);

    localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [Add_W-1:0] STRIDE_A = Add_W'(STRIDE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cols_q, cols_d;
    logic [CNT_W-1:0] rows_q, rows_d;
    logic [Add_W-1:0] pitch_q, pitch_d;
    logic [Add_W-1:0] row_base_q, row_base_d;
    logic [Add_W-1:0] addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] col_cnt, col_nxt;
    logic [CNT_W-1:0] row_cnt, row_nxt;
    logic             col_carry, row_carry;
    logic             start_ok, load, scan_end, advance, col_ce, row_ce;

    assign start_ok = (COLS != '0) && (ROWS != '0);
    assign load     = !SCLR && (state_q == ST_IDLE) && START && start_ok;
    // Both counters at their terminal value: the current point is the last.
    assign scan_end = col_carry && row_carry;
    assign advance  = !SCLR && (state_q == ST_RUN) && CE && !scan_end;
    assign col_ce   = advance;
    assign row_ce   = advance && col_carry;

    mod_counter #(.CNT_W(CNT_W)) u_col (
        .clk_i       (CLK),
        .rst_i       (RST),
        .ce_i        (col_ce),
        .sclr_i      (SCLR),
        .load_zero_i (load),
        .step_i      (STRIDE_C),
        .limit_i     (cols_q),
        .count_o     (col_cnt),
        .count_nxt_o (col_nxt),
        .carry_o     (col_carry)
    );

    mod_counter #(.CNT_W(CNT_W)) u_row (
        .clk_i       (CLK),
        .rst_i       (RST),
        .ce_i        (row_ce),
        .sclr_i      (SCLR),
        .load_zero_i (load),
        .step_i      (ONE_C),
        .limit_i     (rows_q),
        .count_o     (row_cnt),
        .count_nxt_o (row_nxt),
        .carry_o     (row_carry)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (SCLR) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (START) state_d = start_ok ? ST_RUN : ST_FIN;
                ST_RUN:  if (CE && scan_end) state_d = ST_FIN;
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values (all outputs are registered below)
    always_comb begin
        cols_d     = cols_q;
        rows_d     = rows_q;
        pitch_d    = pitch_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;

        if (load) begin
            cols_d  = COLS;
            rows_d  = ROWS;
            pitch_d = PITCH;
        end

        if (SCLR || load) begin
            row_base_d = '0;
            addr_d     = '0;
        end else if (row_ce) begin
            // New row: address restarts at the next row base.
            row_base_d = row_base_q + pitch_q;
            addr_d     = row_base_q + pitch_q;
        end else if (col_ce) begin
            addr_d = addr_q + STRIDE_A;
        end

        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_FIN);
        // Look ahead on the counters' next values so LAST is aligned with
        // the point it describes; this also covers the first point at load.
        last_d  = (state_d == ST_RUN)
               && (({1'b0, col_nxt} + {1'b0, STRIDE_C}) >= {1'b0, cols_d})
               && (({1'b0, row_nxt} + {1'b0, ONE_C})    >= {1'b0, rows_d});
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cols_q     <= '0;
            rows_q     <= '0;
            pitch_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            pitch_q    <= pitch_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign COL_Q       = col_cnt;
    assign ROW_Q       = row_cnt;
    assign ADDR        = addr_q;
    assign VALID       = valid_q;
    assign LAST        = last_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_window_counter.sv
// Bench for window_counter: three instances (default, STRIDE=2, Add_W=4)
// share one stimulus stream; a point-index model predicts every output.
module tb_window_counter;
  import window_counter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, ce, sclr;
  logic [4:0] cols, rows;
  logic [9:0] pitch;

  logic [4:0] d_col[3];
  logic [4:0] d_row[3];
  logic [9:0] d_addr[3];
  logic       d_valid[3];
  logic       d_last[3];
  logic       d_busy[3];
  logic       d_done[3];
  logic [1:0] d_st[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SW = (g == 1) ? 2 : 1;
    localparam int AW = (g == 2) ? 4 : 10;
    logic [AW-1:0] addr;
    logic [4:0]    col, row;
    logic          valid, last, busy, done;
    state_t        st;
    window_counter #(.Add_W(AW), .CNT_W(5), .STRIDE(SW)) u_dut (
      .CLK(clk), .RST(rst), .START(start), .CE(ce), .SCLR(sclr),
      .COLS(cols), .ROWS(rows), .PITCH(pitch[AW-1:0]),
      .COL_Q(col), .ROW_Q(row), .ADDR(addr), .VALID(valid), .LAST(last),
      .BUSY(busy), .DONE(done), .dbg_state_o(st)
    );
    assign d_col[g]   = col;
    assign d_row[g]   = row;
    assign d_addr[g]  = 10'(addr);
    assign d_valid[g] = valid;
    assign d_last[g]  = last;
    assign d_busy[g]  = busy;
    assign d_done[g]  = done;
    assign d_st[g]    = st;
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_seq(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_len"}, act.size(), exp.size());
    for (int j = 0; j < exp.size(); j++)
      chk($sformatf("%s_%0d", nm, j), (j < act.size()) ? act[j] : -1, exp[j]);
  endtask

  // ---------------- behavioural model ----------------
  // A scan is a list of points k = 0..total-1; point k sits at
  // row k/n, column (k%n)*stride, where n = ceil(cols/stride).
  int stride_p[3] = '{1, 2, 1};
  int mask_p[3]   = '{1023, 1023, 15};
  int m_mode[3];  // 0 idle, 1 scanning, 2 finishing
  int m_k[3], m_n[3], m_total[3], m_pitch[3];
  int m_col[3], m_row[3], m_addr[3];

  task automatic set_point(input int i);
    m_col[i]  = (m_k[i] % m_n[i]) * stride_p[i];
    m_row[i]  = m_k[i] / m_n[i];
    m_addr[i] = (m_row[i] * m_pitch[i] + m_col[i]) & mask_p[i];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_k[i] = 0; m_n[i] = 1; m_total[i] = 1; m_pitch[i] = 0;
      m_col[i] = 0; m_row[i] = 0; m_addr[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (sclr) begin
        m_mode[i] = 0; m_col[i] = 0; m_row[i] = 0; m_addr[i] = 0;
      end else begin
        case (m_mode[i])
          0: if (start) begin
               if (cols != 0 && rows != 0) begin
                 m_n[i]     = (int'(cols) + stride_p[i] - 1) / stride_p[i];
                 m_total[i] = m_n[i] * int'(rows);
                 m_pitch[i] = int'(pitch) & mask_p[i];
                 m_k[i]     = 0;
                 set_point(i);
                 m_mode[i]  = 1;
               end else begin
                 m_mode[i] = 2;
               end
             end
          1: if (ce) begin
               if (m_k[i] == m_total[i] - 1) m_mode[i] = 2;
               else begin
                 m_k[i]++;
                 set_point(i);
               end
             end
          default: m_mode[i] = 0;
        endcase
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process + point logs ----------------
  int lg_addr0[$], lg_last0[$], lg_col1[$], lg_addr1[$], lg_addr2[$];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_col", i),   int'(d_col[i]),   m_col[i]);
        chk($sformatf("i%0d_row", i),   int'(d_row[i]),   m_row[i]);
        chk($sformatf("i%0d_addr", i),  int'(d_addr[i]),  m_addr[i]);
        chk($sformatf("i%0d_valid", i), int'(d_valid[i]), int'(m_mode[i] == 1));
        chk($sformatf("i%0d_busy", i),  int'(d_busy[i]),  int'(m_mode[i] == 1));
        chk($sformatf("i%0d_last", i),  int'(d_last[i]),
            int'(m_mode[i] == 1 && m_k[i] == m_total[i] - 1));
        chk($sformatf("i%0d_done", i),  int'(d_done[i]),  int'(m_mode[i] == 2));
      end
      // A point shown with CE=1 is consumed at the coming edge.
      if (ce && d_valid[0]) begin
        lg_addr0.push_back(int'(d_addr[0]));
        lg_last0.push_back(int'(d_last[0]));
      end
      if (ce && d_valid[1]) begin
        lg_col1.push_back(int'(d_col[1]));
        lg_addr1.push_back(int'(d_addr[1]));
      end
      if (ce && d_valid[2]) lg_addr2.push_back(int'(d_addr[2]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    lg_addr0 = {}; lg_last0 = {}; lg_col1 = {}; lg_addr1 = {}; lg_addr2 = {};
  endtask

  task automatic start_scan(input int c, input int r, input int p);
    cols = 5'(c); rows = 5'(r); pitch = 10'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      tick();
      cnt++;
      if (d_done[i]) break;
    end
    if (!d_done[i]) chk($sformatf("i%0d_done_timeout", i), 0, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int cnt, cnt2;
    int e[$];
    int e2[$];
    rst = 1'b1; start = 1'b0; ce = 1'b0; sclr = 1'b0;
    cols = '0; rows = '0; pitch = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_addr", int'(d_addr[0]), 0);
    chk("rst_valid", int'(d_valid[0]), 0);
    chk("rst_state", int'(d_st[0]), int'(ST_IDLE));

    // 3x2 window, pitch 8, CE held high
    ce = 1'b1;
    tick();
    clear_logs();
    start_scan(3, 2, 8);
    chk("t1_first_addr", int'(d_addr[0]), 0);
    chk("t1_first_valid", int'(d_valid[0]), 1);
    wait_done(0, 40, cnt);
    chk("t1_done_latency", cnt, 6);
    tick();
    chk("t1_done_width", int'(d_done[0]), 0);
    e = {0, 1, 2, 8, 9, 10};
    chk_seq("t1_addr", lg_addr0, e);
    e = {0, 0, 0, 0, 0, 1};
    chk_seq("t1_last", lg_last0, e);
    repeat (2) tick();

    // stride 2 over 5 columns; limits change mid-scan and must not matter
    clear_logs();
    start_scan(5, 2, 16);
    cols = 5'd2; rows = 5'd1; pitch = 10'd3;
    wait_done(1, 40, cnt);
    chk("t2_done_latency_s2", cnt, 6);
    wait_done(0, 20, cnt2);
    chk("t2_done_latency_s1", cnt2, 4);
    e = {0, 2, 4, 0, 2, 4};
    chk_seq("t2_col", lg_col1, e);
    e = {0, 2, 4, 16, 18, 20};
    chk_seq("t2_addr", lg_addr1, e);
    repeat (2) tick();

    // CE toggling 1,0,1,0...; a START pulse mid-scan is ignored
    clear_logs();
    ce = 1'b1;
    start_scan(3, 2, 8);
    cnt = 0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (d_done[0]) break;
      ce = ~ce;
      if (cnt == 4) start = 1'b1;
      if (cnt == 5) start = 1'b0;
    end
    chk("t3_done_seen", int'(d_done[0]), 1);
    chk("t3_done_latency", cnt, 11);
    e = {0, 1, 2, 8, 9, 10};
    chk_seq("t3_addr", lg_addr0, e);
    ce = 1'b1;
    repeat (3) tick();

    // SCLR at the 4th point
    start_scan(3, 2, 8);
    repeat (3) tick();
    chk("t4_4th_addr", int'(d_addr[0]), 8);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("t4_addr", int'(d_addr[0]), 0);
    chk("t4_row", int'(d_row[0]), 0);
    chk("t4_valid", int'(d_valid[0]), 0);
    chk("t4_busy", int'(d_busy[0]), 0);
    chk("t4_done", int'(d_done[0]), 0);
    chk("t4_state", int'(d_st[0]), int'(ST_IDLE));
    repeat (3) begin
      tick();
      chk("t4_no_done", int'(d_done[0]), 0);
    end
    start_scan(3, 2, 8);
    chk("t4_restart_addr", int'(d_addr[0]), 0);
    chk("t4_restart_valid", int'(d_valid[0]), 1);
    wait_done(0, 40, cnt);
    chk("t4_restart_latency", cnt, 6);
    repeat (2) tick();

    // zero-size window: straight to the completion pulse
    start_scan(0, 2, 8);
    chk("t5_zero_done", int'(d_done[0]), 1);
    chk("t5_zero_valid", int'(d_valid[0]), 0);
    chk("t5_zero_state", int'(d_st[0]), int'(ST_FIN));
    tick();
    chk("t5_zero_done_end", int'(d_done[0]), 0);
    chk("t5_zero_idle", int'(d_st[0]), int'(ST_IDLE));

    // asynchronous reset in the middle of a scan
    start_scan(3, 2, 8);
    repeat (2) tick();
    chk("t5_pre_rst_addr", int'(d_addr[0]), 2);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_addr", int'(d_addr[0]), 0);
    chk("t5_rst_col", int'(d_col[0]), 0);
    chk("t5_rst_valid", int'(d_valid[0]), 0);
    chk("t5_rst_busy", int'(d_busy[0]), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("t5_no_done", int'(d_done[0]), 0);
    end

    // 4-bit address wrap: 1x3 window, pitch 12
    clear_logs();
    start_scan(1, 3, 12);
    wait_done(2, 20, cnt);
    chk("t6_done_latency", cnt, 3);
    e2 = {0, 12, 8};
    chk_seq("t6_addr", lg_addr2, e2);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
